// File: rtl/matmul_apb_arb_if.sv
// Two-requester APB bundle for the matmul arbiter: requester ports m0/m1 and downstream slave port.
// Latency: none (signal bundle only).
// Backpressure: carried by s_pready_i toward the requesters through mN_pready_o.
// Modports: slave = arbiter view (takes requests, drives matmul APB master side);
//           master = environment view (drives requesters and the matmul slave response).
interface matmul_apb_arb_if #(
   parameter int BUS_WIDTH  = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MAX_DIM    = 4
) ();
   // requester 0
   logic                  m0_psel_i;
   logic                  m0_penable_i;
   logic                  m0_pwrite_i;
   logic [ADDR_WIDTH-1:0] m0_paddr_i;
   logic [BUS_WIDTH-1:0]  m0_pwdata_i;
   logic [MAX_DIM-1:0]    m0_pstrb_i;
   logic [BUS_WIDTH-1:0]  m0_prdata_o;
   logic                  m0_pready_o;
   logic                  m0_pslverr_o;
   // requester 1
   logic                  m1_psel_i;
   logic                  m1_penable_i;
   logic                  m1_pwrite_i;
   logic [ADDR_WIDTH-1:0] m1_paddr_i;
   logic [BUS_WIDTH-1:0]  m1_pwdata_i;
   logic [MAX_DIM-1:0]    m1_pstrb_i;
   logic [BUS_WIDTH-1:0]  m1_prdata_o;
   logic                  m1_pready_o;
   logic                  m1_pslverr_o;
   // downstream matmul slave
   logic                  s_psel_o;
   logic                  s_penable_o;
   logic                  s_pwrite_o;
   logic [ADDR_WIDTH-1:0] s_paddr_o;
   logic [BUS_WIDTH-1:0]  s_pwdata_o;
   logic [MAX_DIM-1:0]    s_pstrb_o;
   logic [BUS_WIDTH-1:0]  s_prdata_i;
   logic                  s_pready_i;
   logic                  s_pslverr_i;
   // ownership
   logic [1:0]            grant_o;

   modport slave (
      input  m0_psel_i, m0_penable_i, m0_pwrite_i, m0_paddr_i, m0_pwdata_i, m0_pstrb_i,
      output m0_prdata_o, m0_pready_o, m0_pslverr_o,
      input  m1_psel_i, m1_penable_i, m1_pwrite_i, m1_paddr_i, m1_pwdata_i, m1_pstrb_i,
      output m1_prdata_o, m1_pready_o, m1_pslverr_o,
      output s_psel_o, s_penable_o, s_pwrite_o, s_paddr_o, s_pwdata_o, s_pstrb_o,
      input  s_prdata_i, s_pready_i, s_pslverr_i,
      output grant_o
   );

   modport master (
      output m0_psel_i, m0_penable_i, m0_pwrite_i, m0_paddr_i, m0_pwdata_i, m0_pstrb_i,
      input  m0_prdata_o, m0_pready_o, m0_pslverr_o,
      output m1_psel_i, m1_penable_i, m1_pwrite_i, m1_paddr_i, m1_pwdata_i, m1_pstrb_i,
      input  m1_prdata_o, m1_pready_o, m1_pslverr_o,
      input  s_psel_o, s_penable_o, s_pwrite_o, s_paddr_o, s_pwdata_o, s_pstrb_o,
      output s_prdata_i, s_pready_i, s_pslverr_i,
      input  grant_o
   );
endinterface

// File: rtl/matmul_apb_arb.sv
// Round-robin arbiter muxing two APB requesters onto one matmul APB slave.
// Latency: request seen in IDLE at cycle 0 -> earliest requester pready at cycle 2; one idle cycle between transfers.
// Backpressure: ACCESS holds until s_pready_i (or timeout when MATMUL_ARB_TIMEOUT_EN is defined); losers wait with psel held.
// Ports: clk_i, rst_ni (async active-low), bus (matmul_apb_arb_if.slave: m0/m1 requesters, s_* slave side, grant_o).
// Optional feature macro: MATMUL_ARB_TIMEOUT_EN -- aborts ACCESS with pslverr after TIMEOUT_CYCLES waiting cycles.
module matmul_apb_arb #(
   parameter int BUS_WIDTH      = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int MAX_DIM        = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic             clk_i,
   input logic             rst_ni,
   matmul_apb_arb_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t                r_state;
   logic [1:0]            r_grant;
   logic                  r_last_m1;   // 1: m1 was served last, so m0 wins a tie
   logic                  r_psel;
   logic                  r_penable;
   logic                  r_pwrite;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic [BUS_WIDTH-1:0]  r_pwdata;
   logic [MAX_DIM-1:0]    r_pstrb;

   logic                  w_req;
   logic                  w_pick_m1;
   logic                  w_timeout;
   logic                  w_done;
   logic                  w_m0_pready;
   logic                  w_m0_pslverr;
   logic [BUS_WIDTH-1:0]  w_m0_prdata;
   logic                  w_m1_pready;
   logic                  w_m1_pslverr;
   logic [BUS_WIDTH-1:0]  w_m1_prdata;

   assign w_req     = bus.m0_psel_i | bus.m1_psel_i;
   // m1 wins when it is the only requester, or on a tie when m0 was served last
   assign w_pick_m1 = bus.m1_psel_i & (~bus.m0_psel_i | ~r_last_m1);

`ifdef MATMUL_ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0] r_wait_cnt;
   // fires on the TIMEOUT_CYCLES-th ACCESS cycle without pready
   assign w_timeout = (r_state == ST_ACCESS) && !bus.s_pready_i &&
                      (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   assign w_done = (r_state == ST_ACCESS) && (bus.s_pready_i || w_timeout);

   // Completion is returned in the same cycle the slave answers. A granted requester
   // that has left its access phase gets nothing: the response is dropped.
   always_comb begin
      w_m0_pready  = 1'b0;
      w_m0_pslverr = 1'b0;
      w_m0_prdata  = '0;
      w_m1_pready  = 1'b0;
      w_m1_pslverr = 1'b0;
      w_m1_prdata  = '0;
      if (w_done) begin
         if (r_grant[0] && bus.m0_psel_i && bus.m0_penable_i) begin
            w_m0_pready  = 1'b1;
            w_m0_pslverr = w_timeout ? 1'b1 : bus.s_pslverr_i;
            w_m0_prdata  = w_timeout ? '0 : bus.s_prdata_i;
         end
         if (r_grant[1] && bus.m1_psel_i && bus.m1_penable_i) begin
            w_m1_pready  = 1'b1;
            w_m1_pslverr = w_timeout ? 1'b1 : bus.s_pslverr_i;
            w_m1_prdata  = w_timeout ? '0 : bus.s_prdata_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= ST_IDLE;
         r_grant   <= 2'b00;
         r_last_m1 <= 1'b1;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_pwrite  <= 1'b0;
         r_paddr   <= '0;
         r_pwdata  <= '0;
         r_pstrb   <= '0;
`ifdef MATMUL_ARB_TIMEOUT_EN
         r_wait_cnt <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  r_state   <= ST_SETUP;
                  r_grant   <= w_pick_m1 ? 2'b10 : 2'b01;
                  r_psel    <= 1'b1;
                  r_penable <= 1'b0;
                  r_pwrite  <= w_pick_m1 ? bus.m1_pwrite_i : bus.m0_pwrite_i;
                  r_paddr   <= w_pick_m1 ? bus.m1_paddr_i  : bus.m0_paddr_i;
                  r_pwdata  <= w_pick_m1 ? bus.m1_pwdata_i : bus.m0_pwdata_i;
                  r_pstrb   <= w_pick_m1 ? bus.m1_pstrb_i  : bus.m0_pstrb_i;
               end
            end
            ST_SETUP: begin
               r_state   <= ST_ACCESS;
               r_penable <= 1'b1;
`ifdef MATMUL_ARB_TIMEOUT_EN
               r_wait_cnt <= '0;
`endif
            end
            ST_ACCESS: begin
               if (w_done) begin
                  r_state   <= ST_IDLE;
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_grant   <= 2'b00;
                  r_last_m1 <= r_grant[1];
               end
`ifdef MATMUL_ARB_TIMEOUT_EN
               else begin
                  r_wait_cnt <= r_wait_cnt + CNT_W'(1);
               end
`endif
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.s_psel_o     = r_psel;
   assign bus.s_penable_o  = r_penable;
   assign bus.s_pwrite_o   = r_pwrite;
   assign bus.s_paddr_o    = r_paddr;
   assign bus.s_pwdata_o   = r_pwdata;
   assign bus.s_pstrb_o    = r_pstrb;
   assign bus.grant_o      = r_grant;
   assign bus.m0_pready_o  = w_m0_pready;
   assign bus.m0_pslverr_o = w_m0_pslverr;
   assign bus.m0_prdata_o  = w_m0_prdata;
   assign bus.m1_pready_o  = w_m1_pready;
   assign bus.m1_pslverr_o = w_m1_pslverr;
   assign bus.m1_prdata_o  = w_m1_prdata;

endmodule

// File: tb/tb_matmul_apb_arb.sv
// Directed bench for matmul_apb_arb: vector table of single transfers plus hand sequences
// for round-robin, dropped requester, reset mid-transfer and the ACCESS wait limit.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_matmul_apb_arb;
   localparam int BW = 32;
   localparam int AW = 32;
   localparam int SW = 4;

   typedef struct {
      logic          req_m1;
      logic          wr;
      logic [AW-1:0] addr;
      logic [BW-1:0] wdata;
      logic [SW-1:0] strb;
      int            wait_cyc;
      logic [BW-1:0] rdata;
      logic          err;
      logic [BW-1:0] exp_prdata;
      logic          exp_err;
   } vec_t;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs [4];
   logic [1:0] rr_exp [11];

   always #5 clk_i = ~clk_i;

   matmul_apb_arb_if #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .MAX_DIM(SW)) bus ();

   matmul_apb_arb #(
      .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .MAX_DIM(SW), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .bus   (bus.slave)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic sample();
      @(negedge clk_i);
   endtask

   task automatic set_req(input logic m1, input logic psel, input logic pen, input logic wr,
                          input logic [AW-1:0] addr, input logic [BW-1:0] wdata,
                          input logic [SW-1:0] strb);
      if (m1) begin
         bus.m1_psel_i = psel; bus.m1_penable_i = pen; bus.m1_pwrite_i = wr;
         bus.m1_paddr_i = addr; bus.m1_pwdata_i = wdata; bus.m1_pstrb_i = strb;
      end else begin
         bus.m0_psel_i = psel; bus.m0_penable_i = pen; bus.m0_pwrite_i = wr;
         bus.m0_paddr_i = addr; bus.m0_pwdata_i = wdata; bus.m0_pstrb_i = strb;
      end
   endtask

   task automatic idle_inputs();
      set_req(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      set_req(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      bus.s_pready_i  = 1'b0;
      bus.s_prdata_i  = '0;
      bus.s_pslverr_i = 1'b0;
   endtask

   function automatic logic rd_pready(input logic m1);
      return m1 ? bus.m1_pready_o : bus.m0_pready_o;
   endfunction
   function automatic logic rd_pslverr(input logic m1);
      return m1 ? bus.m1_pslverr_o : bus.m0_pslverr_o;
   endfunction
   function automatic logic [BW-1:0] rd_prdata(input logic m1);
      return m1 ? bus.m1_prdata_o : bus.m0_prdata_o;
   endfunction

   task automatic check_quiet(input string t);
      chk({t, "_grant"},   bus.grant_o,     2'b00);
      chk({t, "_s_psel"},  bus.s_psel_o,    1'b0);
      chk({t, "_s_pen"},   bus.s_penable_o, 1'b0);
      chk({t, "_m0_rdy"},  bus.m0_pready_o, 1'b0);
      chk({t, "_m1_rdy"},  bus.m1_pready_o, 1'b0);
   endtask

   task automatic run_txn(input vec_t v, input int idx);
      string      t;
      logic [1:0] g;
      t = $sformatf("v%0d", idx);
      g = v.req_m1 ? 2'b10 : 2'b01;
      // cycle 0: request enters setup phase, arbiter idle
      next_cycle();
      set_req(v.req_m1, 1'b1, 1'b0, v.wr, v.addr, v.wdata, v.strb);
      sample();
      chk({t, "_c0_grant"}, bus.grant_o, 2'b00);
      // cycle 1: arbiter SETUP; requester scrambles its fields, latched copy must hold
      next_cycle();
      set_req(v.req_m1, 1'b1, 1'b1, ~v.wr, ~v.addr, ~v.wdata, ~v.strb);
      sample();
      chk({t, "_c1_grant"},  bus.grant_o,     g);
      chk({t, "_c1_psel"},   bus.s_psel_o,    1'b1);
      chk({t, "_c1_pen"},    bus.s_penable_o, 1'b0);
      chk({t, "_c1_pwrite"}, bus.s_pwrite_o,  v.wr);
      chk({t, "_c1_paddr"},  bus.s_paddr_o,   v.addr);
      chk({t, "_c1_pwdata"}, bus.s_pwdata_o,  v.wdata);
      chk({t, "_c1_pstrb"},  bus.s_pstrb_o,   v.strb);
      chk({t, "_c1_rdy"},    rd_pready(v.req_m1), 1'b0);
      // ACCESS: slave shows data early, pready only on the last cycle
      for (int c = 0; c <= v.wait_cyc; c++) begin
         next_cycle();
         bus.s_prdata_i  = v.rdata;
         bus.s_pslverr_i = v.err;
         bus.s_pready_i  = (c == v.wait_cyc);
         sample();
         chk($sformatf("%s_a%0d_psel", t, c), bus.s_psel_o,    1'b1);
         chk($sformatf("%s_a%0d_pen", t, c),  bus.s_penable_o, 1'b1);
         chk($sformatf("%s_a%0d_grant", t, c), bus.grant_o,    g);
         if (c == v.wait_cyc) begin
            chk({t, "_done_rdy"},     rd_pready(v.req_m1),   1'b1);
            chk({t, "_done_prdata"},  rd_prdata(v.req_m1),   v.exp_prdata);
            chk({t, "_done_slverr"},  rd_pslverr(v.req_m1),  v.exp_err);
            chk({t, "_other_rdy"},    rd_pready(!v.req_m1),  1'b0);
            chk({t, "_other_prdata"}, rd_prdata(!v.req_m1),  '0);
         end else begin
            chk($sformatf("%s_a%0d_rdy", t, c),    rd_pready(v.req_m1),  1'b0);
            chk($sformatf("%s_a%0d_prdata", t, c), rd_prdata(v.req_m1),  '0);
            chk($sformatf("%s_a%0d_slverr", t, c), rd_pslverr(v.req_m1), 1'b0);
         end
      end
      next_cycle();
      idle_inputs();
      sample();
      check_quiet({t, "_after"});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      //         m1    wr    addr          wdata         strb  wait rdata         err   exp_prdata    exp_err
      vecs[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 4'hF, 0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 4'h0, 5, 32'h0000_1234, 1'b1, 32'h0000_1234, 1'b1};
      vecs[2] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h1111_2222, 4'h0, 2, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'h5, 1, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
      rr_exp = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};

      // reset: requests asserted while held in reset must be ignored
      idle_inputs();
      bus.m0_psel_i = 1'b1;
      #2;
      check_quiet("rst");
      chk("rst_paddr", bus.s_paddr_o, '0);
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("rst_hold_grant", bus.grant_o, 2'b00);
      idle_inputs();
      rst_ni = 1'b1;

      for (int i = 0; i < 4; i++) run_txn(vecs[i], i);

      // round-robin: both requesters hold psel, slave always ready
      @(negedge clk_i); rst_ni = 1'b0;
      @(negedge clk_i); rst_ni = 1'b1;
      next_cycle();
      set_req(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, '0, 4'hF);
      set_req(1'b1, 1'b1, 1'b0, 1'b0, 32'h200, '0, 4'hF);
      bus.s_pready_i = 1'b1;
      bus.s_prdata_i = 32'h55;
      sample();
      chk("rr_c0_grant", bus.grant_o, 2'b00);
      for (int k = 0; k < 11; k++) begin
         next_cycle();
         bus.m0_penable_i = 1'b1;
         bus.m1_penable_i = 1'b1;
         sample();
         chk($sformatf("rr%0d_grant", k), bus.grant_o, rr_exp[k]);
         chk($sformatf("rr%0d_m0_rdy", k), bus.m0_pready_o, (k == 1 || k == 7));
         chk($sformatf("rr%0d_m1_rdy", k), bus.m1_pready_o, (k == 4 || k == 10));
         if (rr_exp[k] != 2'b00)
            chk($sformatf("rr%0d_paddr", k), bus.s_paddr_o, (rr_exp[k] == 2'b01) ? 32'h100 : 32'h200);
      end
      next_cycle();
      idle_inputs();
      sample();
      check_quiet("rr_end");

      // granted requester drops out during SETUP: transfer finishes, response dropped
      next_cycle();
      set_req(1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h77, 4'hF);
      sample();
      next_cycle();
      set_req(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      sample();
      chk("drop_c1_grant", bus.grant_o, 2'b01);
      chk("drop_c1_psel", bus.s_psel_o, 1'b1);
      next_cycle();
      sample();
      chk("drop_c2_psel", bus.s_psel_o, 1'b1);
      chk("drop_c2_pen", bus.s_penable_o, 1'b1);
      next_cycle();
      bus.s_pready_i = 1'b1;
      bus.s_prdata_i = 32'hCAFE;
      sample();
      chk("drop_done_grant", bus.grant_o, 2'b01);
      chk("drop_done_rdy", bus.m0_pready_o, 1'b0);
      chk("drop_done_prdata", bus.m0_prdata_o, '0);
      next_cycle();
      idle_inputs();
      sample();
      check_quiet("drop_end");

      // reset during ACCESS
      next_cycle();
      set_req(1'b1, 1'b1, 1'b0, 1'b0, 32'h80, '0, 4'h3);
      sample();
      next_cycle();
      bus.m1_penable_i = 1'b1;
      sample();
      next_cycle();
      sample();
      chk("mrst_pre_pen", bus.s_penable_o, 1'b1);
      #2;
      rst_ni = 1'b0;
      bus.s_pready_i = 1'b1;
      bus.s_prdata_i = 32'h77;
      #1;
      check_quiet("mrst");
      chk("mrst_paddr", bus.s_paddr_o, '0);
      chk("mrst_m1_prdata", bus.m1_prdata_o, '0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      set_req(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         sample();
         check_quiet($sformatf("mrst_post%0d", k));
      end
      idle_inputs();
      run_txn(vecs[2], 10);

      // ACCESS wait limit
      next_cycle();
      set_req(1'b0, 1'b1, 1'b0, 1'b0, 32'h300, '0, 4'hF);
      sample();
      next_cycle();
      bus.m0_penable_i = 1'b1;
      sample();
`ifdef MATMUL_ARB_TIMEOUT_EN
      for (int a = 0; a < 16; a++) begin
         next_cycle();
         bus.s_prdata_i = 32'hBAD;
         sample();
         chk($sformatf("to_a%0d_psel", a), bus.s_psel_o, 1'b1);
         chk($sformatf("to_a%0d_rdy", a), bus.m0_pready_o, (a == 15));
         if (a == 15) begin
            chk("to_slverr", bus.m0_pslverr_o, 1'b1);
            chk("to_prdata", bus.m0_prdata_o, '0);
         end
      end
      next_cycle();
      sample();
      check_quiet("to_after");
`else
      for (int a = 0; a < 20; a++) begin
         next_cycle();
         bus.s_prdata_i = 32'hBAD;
         sample();
         chk($sformatf("nto_a%0d_pen", a), bus.s_penable_o, 1'b1);
         chk($sformatf("nto_a%0d_rdy", a), bus.m0_pready_o, 1'b0);
      end
      next_cycle();
      bus.s_pready_i = 1'b1;
      bus.s_prdata_i = 32'h42;
      sample();
      chk("nto_done_rdy", bus.m0_pready_o, 1'b1);
      chk("nto_done_prdata", bus.m0_prdata_o, 32'h42);
      chk("nto_done_slverr", bus.m0_pslverr_o, 1'b0);
      next_cycle();
      idle_inputs();
      sample();
      check_quiet("nto_after");
`endif
      idle_inputs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
